lc_stream_source: RTL and testbench

//   AXI-stream transmitter: the source side of the in_tdata/in_tvalid/in_tready

---
 rtl/lc_stream_source.sv | 131 +++++++++++++
 tb/tb_lc_stream_source.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/lc_stream_source.sv
// rtl/lc_stream_source.sv - FIFO-backed AXI-stream packet source (optional STREAM_SRC_STATS_EN adds beats_sent)
module lc_stream_source #(
    parameter int DATA_SIZE = 32,
    parameter int DEPTH     = 16,
    parameter int LEN_SIZE  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_SIZE-1:0]       wr_data,
    input  logic                       wr_en,
    output logic                       wr_full,
    output logic [$clog2(DEPTH):0]     fifo_count,
    input  logic                       start,
    input  logic [LEN_SIZE-1:0]        start_len,
    output logic                       busy,
    output logic                       done,
    output logic [DATA_SIZE-1:0]       out_tdata,
    output logic                       out_tvalid,
    output logic                       out_tlast,
    input  logic                       out_tready
`ifdef STREAM_SRC_STATS_EN
    ,
    output logic [31:0]                beats_sent
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t                state;
    state_t                state_next;
    logic [LEN_SIZE-1:0]   rem;
    logic [LEN_SIZE-1:0]   rem_next;
    logic [DATA_SIZE-1:0]  mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic                  wr_accept;
    logic                  pop;

    assign wr_full    = (count == (AW+1)'(DEPTH));
    assign wr_accept  = wr_en && !wr_full;
    assign fifo_count = count;
    assign busy       = (state != IDLE);
    // Gate the head with occupancy so the port reads 0, never X, from an unwritten array.
    assign out_tdata  = (count != '0) ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(wr_accept) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rem   <= '0;
        end else begin
            state <= state_next;
            rem   <= rem_next;
        end
    end

    always_comb begin
        state_next = state;
        rem_next   = rem;
        out_tvalid = 1'b0;
        out_tlast  = 1'b0;
        pop        = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (start_len != '0) begin
                        rem_next   = start_len;
                        state_next = SEND;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            SEND: begin
                // Only a handshake pops, so valid/data/last stay put while stalled.
                out_tvalid = (count != '0);
                out_tlast  = out_tvalid && (rem == LEN_SIZE'(1));
                if (out_tvalid && out_tready) begin
                    pop      = 1'b1;
                    rem_next = rem - 1'b1;
                    if (rem == LEN_SIZE'(1)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef STREAM_SRC_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            beats_sent <= '0;
        end else if (pop) begin
            beats_sent <= beats_sent + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lc_stream_source.sv
// tb/tb_lc_stream_source.sv - self-checking bench for lc_stream_source against a queue-based packet model
module tb_lc_stream_source;

    localparam int DATA_SIZE = 32;
    localparam int DEPTH     = 16;
    localparam int LEN_SIZE  = 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [DATA_SIZE-1:0]    wr_data;
    logic                    wr_en;
    logic                    wr_full;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic                    start;
    logic [LEN_SIZE-1:0]     start_len;
    logic                    busy;
    logic                    done;
    logic [DATA_SIZE-1:0]    out_tdata;
    logic                    out_tvalid;
    logic                    out_tlast;
    logic                    out_tready;
`ifdef STREAM_SRC_STATS_EN
    logic [31:0]             beats_sent;
`endif

    always #5 clk = ~clk;

    lc_stream_source #(
        .DATA_SIZE(DATA_SIZE),
        .DEPTH(DEPTH),
        .LEN_SIZE(LEN_SIZE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_data(wr_data),
        .wr_en(wr_en),
        .wr_full(wr_full),
        .fifo_count(fifo_count),
        .start(start),
        .start_len(start_len),
        .busy(busy),
        .done(done),
        .out_tdata(out_tdata),
        .out_tvalid(out_tvalid),
        .out_tlast(out_tlast),
        .out_tready(out_tready)
`ifdef STREAM_SRC_STATS_EN
        ,
        .beats_sent(beats_sent)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Model: queued words, beats still owed by the open packet, pending done pulse.
    logic [DATA_SIZE-1:0] mq[$];
    int                   rem_m    = 0;
    bit                   active_m = 1'b0;
    bit                   done_m   = 1'b0;
    logic [31:0]          beats_m  = 32'd0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        bit ev;
        ev = active_m && (mq.size() != 0);
        check_eq("fifo_count", 64'(fifo_count), 64'(mq.size()));
        check_eq("wr_full", 64'(wr_full), 64'(mq.size() == DEPTH));
        check_eq("busy", 64'(busy), 64'(active_m || done_m));
        check_eq("done", 64'(done), 64'(done_m));
        check_eq("tvalid", 64'(out_tvalid), 64'(ev));
        check_eq("tlast", 64'(out_tlast), 64'(ev && rem_m == 1));
        if (ev) begin
            check_eq("tdata", 64'(out_tdata), 64'(mq[0]));
        end
`ifdef STREAM_SRC_STATS_EN
        check_eq("beats_sent", 64'(beats_sent), 64'(beats_m));
`endif
    endtask

    task automatic cyc(input logic r, input logic we, input logic [DATA_SIZE-1:0] wd,
                       input logic st, input logic [LEN_SIZE-1:0] sl, input logic rdy);
        bit ev;
        bit hs;
        bit acc;
        @(negedge clk);
        check_outputs();
        rst        = r;
        wr_en      = we;
        wr_data    = wd;
        start      = st;
        start_len  = sl;
        out_tready = rdy;
        ev  = active_m && (mq.size() != 0);
        hs  = ev && rdy;
        acc = we && (mq.size() < DEPTH);
        if (r) begin
            mq.delete();
            rem_m    = 0;
            active_m = 1'b0;
            done_m   = 1'b0;
            beats_m  = 32'd0;
        end else begin
            if (hs) begin
                void'(mq.pop_front());
                beats_m = beats_m + 32'd1;
            end
            if (acc) begin
                mq.push_back(wd);
            end
            if (done_m) begin
                done_m = 1'b0;
            end else if (active_m) begin
                if (hs) begin
                    rem_m--;
                    if (rem_m == 0) begin
                        active_m = 1'b0;
                        done_m   = 1'b1;
                    end
                end
            end else if (st) begin
                if (sl != 0) begin
                    active_m = 1'b1;
                    rem_m    = int'(sl);
                end else begin
                    done_m = 1'b1;
                end
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b0, '0, rdy);
    endtask

    task automatic put(input logic [DATA_SIZE-1:0] d);
        cyc(1'b0, 1'b1, d, 1'b0, '0, 1'b1);
    endtask

    task automatic launch(input logic [LEN_SIZE-1:0] n, input logic rdy);
        cyc(1'b0, 1'b0, '0, 1'b1, n, rdy);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = '0; start = 1'b0; start_len = '0; out_tready = 1'b0;
        @(posedge clk);

        // Reset held with write and start asserted
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 32'hdead0000 + i, 1'b1, 8'd3, 1'b1);
        #1;
        check_eq("rst_tdata", 64'(out_tdata), 64'd0);
        check_eq("rst_count", 64'(fifo_count), 64'd0);
        idle(2, 1'b1);

        // Straight packet
        put(5); put(123); put(5); put(3);
        launch(4, 1'b1);
        idle(7, 1'b1);

        // Backpressure 1,0,0,...
        put(5); put(123); put(5); put(3);
        launch(4, 1'b1);
        for (int i = 0; i < 14; i++) cyc(1'b0, 1'b0, '0, 1'b0, '0, (i % 3) == 0);
        idle(2, 1'b1);

        // Underrun
        put(7);
        launch(3, 1'b1);
        idle(4, 1'b1);
        put(8);
        idle(2, 1'b1);
        put(9);
        idle(4, 1'b1);

        // Overfill then send across pointer wrap
        for (int i = 0; i < DEPTH + 2; i++) cyc(1'b0, 1'b1, 32'h100 + i, 1'b0, '0, 1'b0);
        #1;
        check_eq("full_flag", 64'(wr_full), 64'd1);
        check_eq("full_count", 64'(fifo_count), 64'(DEPTH));
        launch(DEPTH, 1'b1);
        idle(DEPTH + 3, 1'b1);
        put(32'haaa1); put(32'haaa2); put(32'haaa3);
        launch(3, 1'b1);
        idle(6, 1'b1);

        // Zero-length packet, start during SEND, reset mid-packet
        launch(0, 1'b1);
        idle(3, 1'b1);
        put(11); put(12); put(13);
        launch(3, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1, 8'd5, 1'b0);
        idle(6, 1'b1);
        put(21); put(22);
        launch(2, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        #1;
        check_eq("rst_mid_tvalid", 64'(out_tvalid), 64'd0);
        check_eq("rst_mid_count", 64'(fifo_count), 64'd0);
        idle(3, 1'b1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 400) == 0,
                ($urandom % 2) == 0,
                $urandom,
                ($urandom % 8) == 0,
                LEN_SIZE'($urandom_range(0, 6)),
                ($urandom % 3) != 0);
        end
        idle(1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
